// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the add/sub round-robin sequencer.
// Holds the sequencer state encoding, the datapath width and the signed-overflow rule.
package addsub_seq_pkg;

    localparam int DP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

    // Signed overflow of a +/- b given operand and result sign bits.
    function automatic logic calc_ovf(
        input logic sub,
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (~sub & (a_msb == b_msb) & (r_msb != a_msb)) |
               ( sub & (a_msb != b_msb) & (r_msb != a_msb));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Rotating priority scan; exactly one hit at most, so the index can be OR-accumulated.
    always_comb begin
        int  idx_v;
        logic found_v;
        logic hit_v;
        grant     = '0;
        grant_idx = '0;
        found_v   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v          = (int'(last_grant) + k) % N_REQ;
            hit_v          = enable & ~found_v & req[idx_v];
            grant[idx_v]   = hit_v;
            grant_idx      = grant_idx | (hit_v ? IDX_W'(idx_v) : {IDX_W{1'b0}});
            found_v        = found_v | hit_v;
        end
    end

endmodule

// File: rtl/addsub_rr_sequencer.sv
// Shares one registered 8-bit add/sub datapath between N_REQ requesters.
// One operation in flight at a time: accept (IDLE) -> load (ISSUE) -> respond (RESP).
module addsub_rr_sequencer
    import addsub_seq_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = DP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_sub,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_ovf,
    output logic [W-1:0]       dp_a,
    output logic [W-1:0]       dp_b,
    output logic               dp_sub,
    output logic               dp_load,
    input  logic [W-1:0]       dp_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [W-1:0]     op_a_r;
    logic [W-1:0]     op_b_r;
    logic             op_sub_r;
    logic [IDX_W-1:0] op_idx_r;
    logic [IDX_W-1:0] last_grant_r;
    logic [N_REQ-1:0] grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             arb_en_s;
    logic             accept_s;
    logic             rsp_done_s;

    assign arb_en_s   = (state_r == IDLE) & ~reset;
    assign accept_s   = |(req_valid & grant_s);
    assign rsp_done_s = (state_r == RESP) & rsp_ready[op_idx_r];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .enable     (arb_en_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture; the datapath inputs stay stable until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r   <= '0;
            op_b_r   <= '0;
            op_sub_r <= 1'b0;
            op_idx_r <= '0;
        end else if (accept_s) begin
            op_a_r   <= req_a[grant_idx_s*W +: W];
            op_b_r   <= req_b[grant_idx_s*W +: W];
            op_sub_r <= req_sub[grant_idx_s];
            op_idx_r <= grant_idx_s;
        end
    end

    // Round-robin pointer advances only when a response is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= IDX_W'(N_REQ - 1);
        end else if (rsp_done_s) begin
            last_grant_r <= op_idx_r;
        end
    end

    // Output decode; handshake strobes are forced low while reset is asserted.
    always_comb begin
        req_ready = grant_s;
        rsp_valid = '0;
        dp_load   = 1'b0;
        rsp_ovf   = 1'b0;
        if (reset) begin
            req_ready = '0;
        end else if (state_r == ISSUE) begin
            dp_load = 1'b1;
        end else if (state_r == RESP) begin
            rsp_valid[op_idx_r] = 1'b1;
            rsp_ovf = calc_ovf(op_sub_r, op_a_r[W-1], op_b_r[W-1], dp_out[W-1]);
        end else begin
            rsp_valid = '0;
        end
    end

    assign dp_a     = op_a_r;
    assign dp_b     = op_b_r;
    assign dp_sub   = op_sub_r;
    assign rsp_data = dp_out;

endmodule

// File: tb/tb_addsub_rr_sequencer.sv
// Bench for addsub_rr_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_addsub_rr_sequencer;

    localparam int N = 2;
    localparam int W = 8;

    typedef logic [N*W-1:0] opv_t;
    typedef logic [N-1:0]   bv_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    opv_t         req_a;
    opv_t         req_b;
    logic [N-1:0] req_sub;
    logic [N-1:0] rsp_valid;
    logic [N-1:0] rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic [W-1:0] dp_a;
    logic [W-1:0] dp_b;
    logic         dp_sub;
    logic         dp_load;
    logic [W-1:0] dp_out;

    always #5 clk = ~clk;

    addsub_rr_sequencer #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_sub    (dp_sub),
        .dp_load   (dp_load),
        .dp_out    (dp_out)
    );

    // Stand-in for the shared datapath: registered result, holds when not loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_out <= '0;
        end else if (dp_load) begin
            dp_out <= dp_sub ? (dp_a - dp_b) : (dp_a + dp_b);
        end
    end

    // Reference model: one transaction, its age in cycles since acceptance, and the RR pointer.
    bit         m_busy  = 1'b0;
    int         m_age   = 0;
    int         m_owner = 0;
    int         m_last  = N - 1;
    logic [7:0] m_a     = 8'h00;
    logic [7:0] m_b     = 8'h00;
    logic       m_sub   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         acc_idx_q[$];
    int         acc_cyc_q[$];
    int         last_acc_cyc = -100;
    int         cap_cyc = 0;
    bit         cap_seen = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bv_t        exp_ready;
        bv_t        exp_rv;
        logic       exp_load;
        logic [7:0] exp_data;
        logic       exp_ovf;
        int         win;
        int         ri;
        int         sa;
        int         sb;
        int         sres;
        int         ures;
        #2;
        win = -1;
        if (!reset && !m_busy) begin
            for (int k = 1; k <= N; k++) begin
                ri = (m_last + k) % N;
                if (win < 0 && req_valid[ri]) win = ri;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_load = !reset && m_busy && (m_age == 1);
        exp_rv = '0;
        if (!reset && m_busy && m_age >= 2) exp_rv[m_owner] = 1'b1;
        sa   = int'($signed(m_a));
        sb   = int'($signed(m_b));
        sres = m_sub ? sa - sb : sa + sb;
        ures = m_sub ? int'(m_a) - int'(m_b) : int'(m_a) + int'(m_b);
        exp_data = ures[7:0];
        exp_ovf  = (sres > 127) || (sres < -128);

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("dp_load", 32'(dp_load), 32'(exp_load));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("dp_a", 32'(dp_a), 32'(m_a));
        check("dp_b", 32'(dp_b), 32'(m_b));
        check("dp_sub", 32'(dp_sub), 32'(m_sub));
        if (exp_rv != '0) begin
            check("rsp_data", 32'(rsp_data), 32'(exp_data));
            check("rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf));
        end
        if (reset) check("rsp_ovf_rst", 32'(rsp_ovf), 32'h0);

        for (int k = 0; k < N; k++) begin
            if (req_ready[k] && req_valid[k]) begin
                acc_idx_q.push_back(k);
                acc_cyc_q.push_back(cyc);
                last_acc_cyc = cyc;
            end
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            cap_seen = 1'b1;
            cap_data = rsp_data;
            cap_ovf  = rsp_ovf;
            cap_cyc  = cyc;
        end

        if (reset) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_last = N - 1;
            m_a    = 8'h00;
            m_b    = 8'h00;
            m_sub  = 1'b0;
        end else if (!m_busy) begin
            if (win >= 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_owner = win;
                m_a     = req_a[win*W +: W];
                m_b     = req_b[win*W +: W];
                m_sub   = req_sub[win];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rsp_ready[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [7:0] ed, input logic eo);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_sub[idx] = s;
        rsp_ready = '1;
        cap_seen = 1'b0;
        step();
        req_valid = '0;
        for (int k = 0; k < 8 && !cap_seen; k++) step();
        check("op_done", 32'(cap_seen), 32'h1);
        check("op_data", 32'(cap_data), 32'(ed));
        check("op_ovf", 32'(cap_ovf), 32'(eo));
        check("op_latency", 32'(cap_cyc - last_acc_cyc), 32'd2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single add, overflow cases, wrap-around.
        do_op(0, 8'h25, 8'h13, 1'b0, 8'h38, 1'b0);
        do_op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
        do_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
        do_op(1, 8'h00, 8'h80, 1'b1, 8'h80, 1'b1);
        do_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);

        // Contention from reset: grants alternate, accepts every 3 cycles.
        do_reset();
        acc_idx_q.delete();
        acc_cyc_q.delete();
        req_a = 16'h1122;
        req_b = 16'h3344;
        req_sub = 2'b10;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 13; k++) step();
        req_valid = '0;
        check("acc_count", 32'(acc_idx_q.size() >= 4), 32'h1);
        for (int k = 0; k < 4 && k < acc_idx_q.size(); k++) begin
            check("alt_grant", 32'(acc_idx_q[k]), 32'(k % 2));
            if (k > 0) check("acc_space", 32'(acc_cyc_q[k] - acc_cyc_q[k-1]), 32'd3);
        end
        for (int k = 0; k < 4; k++) step();

        // Backpressure on requester 0, with stray rsp_ready[1] and a waiting requester 1.
        req_valid = 2'b01;
        req_a[0 +: W] = 8'h40;
        req_b[0 +: W] = 8'h45;
        req_sub[0] = 1'b1;
        rsp_ready = 2'b00;
        step();
        req_valid = 2'b10;
        step();
        for (int k = 0; k < 6; k++) begin
            rsp_ready = (k % 2 == 1) ? 2'b10 : 2'b00;
            step();
        end
        rsp_ready = 2'b01;
        step();
        req_valid = '0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) step();

        // Reset during ISSUE, then during RESP; requester 0 must win afterwards.
        req_valid = 2'b01;
        step();
        req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req_valid = 2'b10;
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 2'b11;
        step();
        check("post_rst_winner", 32'(acc_idx_q[acc_idx_q.size()-1]), 32'h0);
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 63) == 0);
            req_valid = bv_t'($urandom);
            req_a     = opv_t'($urandom);
            req_b     = opv_t'($urandom);
            req_sub   = bv_t'($urandom);
            rsp_ready = bv_t'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
